// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan block: hex glyph table, idle
// output levels and default timing parameters.
package seg_pkg;

  localparam int unsigned TICK_DIV_DEFAULT     = 100000;
  localparam int unsigned DEAD_CYC_DEFAULT     = 4;
  localparam int unsigned BLINK_FRAMES_DEFAULT = 63;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low g..a glyphs, entry n at index n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_display_scan.sv
// Eight-digit multiplexed seven-segment scanner with dead-time anti-ghosting,
// per-digit blank/blink/dp and frame-synchronous double-buffered content.
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int unsigned TICK_DIV     = TICK_DIV_DEFAULT,
  parameter int unsigned DEAD_CYC     = DEAD_CYC_DEFAULT,
  parameter int unsigned BLINK_FRAMES = BLINK_FRAMES_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        load,
  input  logic [31:0] digit_data,
  input  logic [7:0]  blank_mask,
  input  logic [7:0]  blink_mask,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  AN,
  output logic [7:0]  SEG,
  output logic        pending,
  output logic        applied
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned FrmW = $clog2(BLINK_FRAMES + 1);

  localparam logic [CntW-1:0] SlotLast = CntW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] DeadEnd  = CntW'(DEAD_CYC);
  localparam logic [FrmW-1:0] FrmLast  = FrmW'(BLINK_FRAMES - 1);

  // Scan state
  logic [CntW-1:0] slot_q, slot_d;
  logic [2:0]      idx_q, idx_d;
  logic [FrmW-1:0] frame_q, frame_d;
  logic            blink_q, blink_d;

  // Double-buffered content
  logic [31:0] sh_data_q, act_data_q;
  logic [7:0]  sh_blank_q, act_blank_q;
  logic [7:0]  sh_blink_q, act_blink_q;
  logic [7:0]  sh_dp_q, act_dp_q;
  logic        pending_q, pending_d;
  logic        applied_q, applied_d;

  // Registered outputs
  logic [7:0] an_q, an_d;
  logic [7:0] seg_q, seg_d;

  logic       slot_end;
  logic       frame_end;
  logic       swap;
  logic       dead;
  logic       lit;
  logic [3:0] nibble;
  logic [6:0] hex_seg;

  seg_hex_decode u_hex (
    .nibble (nibble),
    .seg    (hex_seg)
  );

  always_comb begin
    slot_end  = (slot_q == SlotLast);
    frame_end = slot_end && (idx_q == 3'd7);
    swap      = frame_end && pending_q;

    slot_d = slot_end ? '0 : slot_q + 1'b1;
    idx_d  = slot_end ? idx_q + 3'd1 : idx_q;

    frame_d = frame_q;
    blink_d = blink_q;
    if (frame_end) begin
      if (frame_q == FrmLast) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end

    // A load on the boundary cycle refills the shadow after it is consumed.
    pending_d = pending_q;
    if (load) begin
      pending_d = 1'b1;
    end else if (frame_end) begin
      pending_d = 1'b0;
    end
    applied_d = swap;
  end

  always_comb begin
    dead   = (slot_q < DeadEnd);
    nibble = act_data_q[{idx_q, 2'b00} +: 4];
    lit    = !dead && !act_blank_q[idx_q] && !(act_blink_q[idx_q] && blink_q);
    an_d   = AN_OFF;
    seg_d  = SEG_OFF;
    if (lit) begin
      an_d  = ~(8'd1 << idx_q);
      seg_d = {~act_dp_q[idx_q], hex_seg};
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      slot_q    <= '0;
      idx_q     <= '0;
      frame_q   <= '0;
      blink_q   <= 1'b0;
      pending_q <= 1'b0;
      applied_q <= 1'b0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_OFF;
    end else begin
      slot_q    <= slot_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      blink_q   <= blink_d;
      pending_q <= pending_d;
      applied_q <= applied_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sh_data_q  <= '0;
      sh_blank_q <= '0;
      sh_blink_q <= '0;
      sh_dp_q    <= '0;
    end else if (load) begin
      sh_data_q  <= digit_data;
      sh_blank_q <= blank_mask;
      sh_blink_q <= blink_mask;
      sh_dp_q    <= dp_mask;
    end
  end

  // Active content only changes on the last cycle of a frame, so a frame is
  // always drawn from a single snapshot.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      act_data_q  <= '0;
      act_blank_q <= 8'hFF;
      act_blink_q <= '0;
      act_dp_q    <= '0;
    end else if (swap) begin
      act_data_q  <= sh_data_q;
      act_blank_q <= sh_blank_q;
      act_blink_q <= sh_blink_q;
      act_dp_q    <= sh_dp_q;
    end
  end

  assign AN      = an_q;
  assign SEG     = seg_q;
  assign pending = pending_q;
  assign applied = applied_q;

endmodule
